// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus width, FSM state
// encoding and a small index helper.
package mem_bus_arbiter_pkg;

    localparam int BUSWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Index width for a requester count, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled.
// slave = arbiter view, master = the environment driving requests and
// answering on the memory side.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import mem_bus_arbiter_pkg::*;

    // requester side
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0]               rw;
    logic [NUM_REQ-1:0][BUSWIDTH-1:0] addr;
    logic [NUM_REQ-1:0][BUSWIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]               gnt;
    logic [NUM_REQ-1:0]               done;
    logic [BUSWIDTH-1:0]              rdata;
    logic                             err;

    // memory side
    logic                             m_req;
    logic                             m_rw;
    logic [BUSWIDTH-1:0]              m_addr;
    logic [BUSWIDTH-1:0]              m_wdata;
    logic                             m_ack;
    logic [BUSWIDTH-1:0]              m_rdata;

    modport slave (
        input  req, rw, addr, wdata, m_ack, m_rdata,
        output gnt, done, rdata, err, m_req, m_rw, m_addr, m_wdata
    );

    modport master (
        output req, rw, addr, wdata, m_ack, m_rdata,
        input  gnt, done, rdata, err, m_req, m_rw, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin select: scans requesters starting at ptr and
// returns the first one asserted as one-hot, as index, and an any flag.
module mem_bus_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // First asserted request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ))
                sum = sum - (IDX_W+1)'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                winner[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters,
// one transaction in flight. Optional watchdog abort: ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TO_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    resetN,
    mem_bus_arbiter_if.slave        bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [BUSWIDTH-1:0]  rdata_q;
    logic                 m_req_q;
    logic                 m_rw_q;
    logic [BUSWIDTH-1:0]  m_addr_q;
    logic [BUSWIDTH-1:0]  m_wdata_q;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     ptr_next;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);
    logic [CNT_W-1:0]     to_cnt;
    logic                 err_q;
`endif

    mem_bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .winner  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // Pointer moves to the requester just after the one served.
    assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    // Arbitration FSM; every output is a register so reset clears them at once.
    // done/rdata/err are loaded on the BUSY exit so they line up with the
    // DONE cycle, one cycle after m_ack.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            m_req_q   <= 1'b0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q     <= pick_onehot;
                        win_idx   <= pick_idx;
                        m_rw_q    <= bus.rw[pick_idx];
                        m_addr_q  <= bus.addr[pick_idx];
                        m_wdata_q <= bus.wdata[pick_idx];
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    m_req_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= BUSY;
                end
                BUSY: begin
                    if (bus.m_ack) begin
                        if (!m_rw_q)
                            rdata_q <= bus.m_rdata;
                        m_req_q <= 1'b0;
                        done_q  <= gnt_q;
                        state   <= DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TO_CYCLES - 1)) begin
                        rdata_q <= '0;
                        m_req_q <= 1'b0;
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        to_cnt  <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    ptr     <= ptr_next;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.m_req   = m_req_q;
    assign bus.m_rw    = m_rw_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected completions,
// a monitor pops and compares on each done pulse, and a memory responder
// checks the presented fields. Timeout scenario runs with ARB_TIMEOUT_EN.
module tb_mem_bus_arbiter;

    localparam int NR = 4;

    typedef struct {
        int          idx;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.NUM_REQ(NR)) bus();

    mem_bus_arbiter #(.NUM_REQ(NR), .TO_CYCLES(8)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic        resp_en  = 1'b0;
    int          ack_delay = 0;
    logic [15:0] ack_base = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic rw, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd, input logic e);
        exp_t x;
        x.idx = idx; x.rw = rw; x.addr = a; x.wdata = wd; x.rdata = rd; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin tick(1); n++; end
        chk(name, (done_cnt >= target), 1);
    endtask

    // Monitor: each done pulse must match the oldest expected completion.
    always @(negedge clock) begin
        if (resetN && |bus.done) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected: done=%b with nothing expected", bus.done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_done", bus.done, 32'(1) << e.idx);
                chk("sb_gnt", bus.gnt, 32'(1) << e.idx);
                chk("sb_rdata", bus.rdata, e.rdata);
                chk("sb_err", bus.err, e.err);
            end
            done_cnt++;
        end
    end

    // Memory model: acks after ack_delay cycles of m_req, data = ack_base+addr.
    initial begin
        int wc = 0;
        bus.m_ack = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clock); #1;
            bus.m_ack = 1'b0;
            if (resp_en && bus.m_req) begin
                if (wc >= ack_delay) begin
                    if (exp_q.size() > 0) begin
                        chk("mem_addr", bus.m_addr, exp_q[0].addr);
                        chk("mem_rw", bus.m_rw, exp_q[0].rw);
                        if (exp_q[0].rw) chk("mem_wdata", bus.m_wdata, exp_q[0].wdata);
                    end
                    bus.m_ack = 1'b1;
                    bus.m_rdata = ack_base + bus.m_addr;
                    wc = 0;
                end else wc++;
            end else wc = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = '0; bus.rw = '0; bus.addr = '0; bus.wdata = '0;
        tick(2);
        // reset state
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        resetN = 1'b1;
        tick(1);

        // 1: single read, m_req two cycles after req
        bus.rw[0] = 1'b0; bus.addr[0] = 16'h0010;
        ack_base = 16'hBEDF; ack_delay = 3; resp_en = 1'b1;
        push(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        bus.req[0] = 1'b1;
        tick(1);
        chk("lat_m_req_lo", bus.m_req, 0);
        tick(1);
        chk("lat_m_req_hi", bus.m_req, 1);
        chk("t1_m_addr", bus.m_addr, 16'h0010);
        chk("t1_gnt", bus.gnt, 4'b0001);
        wait_done(1, "t1_wait");
        bus.req[0] = 1'b0;

        // 2: single write, rdata must keep BEEF
        bus.rw[2] = 1'b1; bus.addr[2] = 16'h0020; bus.wdata[2] = 16'h1234;
        ack_delay = 1;
        push(2, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0);
        bus.req[2] = 1'b1;
        wait_done(2, "t2_wait");
        bus.req[2] = 1'b0;

        // 5: reset mid-BUSY (ptr is 3 here), then ptr restarts at 0
        bus.rw[1] = 1'b0; bus.addr[1] = 16'h0030;
        resp_en = 1'b0;
        bus.req[1] = 1'b1;
        tick(4);
        chk("t5_busy_m_req", bus.m_req, 1);
        resetN = 1'b0;
        #1;
        chk("t5_rst_m_req", bus.m_req, 0);
        chk("t5_rst_gnt", bus.gnt, 0);
        chk("t5_rst_rdata", bus.rdata, 0);
        chk("t5_rst_m_addr", bus.m_addr, 0);
        tick(1);
        resetN = 1'b1;
        resp_en = 1'b1; ack_base = 16'h0100; ack_delay = 1;
        bus.rw[3] = 1'b0; bus.addr[3] = 16'h0031;
        push(1, 1'b0, 16'h0030, 16'h0000, 16'h0130, 1'b0);
        push(3, 1'b0, 16'h0031, 16'h0000, 16'h0131, 1'b0);
        bus.req[3] = 1'b1;
        wait_done(4, "t5_wait");
        bus.req = '0;

        // 3: all four held, ptr=0 -> 0,1,2,3,0
        for (int i = 0; i < NR; i++) begin
            bus.rw[i] = 1'b0;
            bus.addr[i] = 16'((i + 1) * 16'h0100);
        end
        ack_base = 16'h1000; ack_delay = 0;
        push(0, 1'b0, 16'h0100, 16'h0, 16'h1100, 1'b0);
        push(1, 1'b0, 16'h0200, 16'h0, 16'h1200, 1'b0);
        push(2, 1'b0, 16'h0300, 16'h0, 16'h1300, 1'b0);
        push(3, 1'b0, 16'h0400, 16'h0, 16'h1400, 1'b0);
        push(0, 1'b0, 16'h0100, 16'h0, 16'h1100, 1'b0);
        bus.req = 4'hF;
        wait_done(9, "t3_wait");
        bus.req = '0;

        // 4: req[1] held (write), req[3] toggles (read) -> 1,3,1,3
        bus.rw[1] = 1'b1; bus.addr[1] = 16'h0011; bus.wdata[1] = 16'h1111;
        bus.rw[3] = 1'b0; bus.addr[3] = 16'h0033;
        ack_base = 16'h2000; ack_delay = 2;
        push(1, 1'b1, 16'h0011, 16'h1111, 16'h1100, 1'b0);
        push(3, 1'b0, 16'h0033, 16'h0000, 16'h2033, 1'b0);
        push(1, 1'b1, 16'h0011, 16'h1111, 16'h2033, 1'b0);
        push(3, 1'b0, 16'h0033, 16'h0000, 16'h2033, 1'b0);
        bus.req[1] = 1'b1; bus.req[3] = 1'b1;
        wait_done(11, "t4_wait_a");
        bus.req[3] = 1'b0;
        tick(1);
        bus.req[3] = 1'b1;
        wait_done(13, "t4_wait_b");
        bus.req = '0;

`ifdef ARB_TIMEOUT_EN
        // 6: no ack -> done+err after 8 BUSY cycles, next requester served
        resp_en = 1'b0;
        bus.rw[0] = 1'b0; bus.addr[0] = 16'h0040;
        bus.rw[2] = 1'b0; bus.addr[2] = 16'h0050;
        ack_base = 16'h3000; ack_delay = 0;
        push(0, 1'b0, 16'h0040, 16'h0, 16'h0000, 1'b1);
        push(2, 1'b0, 16'h0050, 16'h0, 16'h3050, 1'b0);
        bus.req[0] = 1'b1; bus.req[2] = 1'b1;
        wait_done(14, "t6_wait_to");
        chk("t6_m_req_drop", bus.m_req, 0);
        bus.req[0] = 1'b0;
        resp_en = 1'b1;
        wait_done(15, "t6_wait_next");
        bus.req = '0;
`endif

        tick(5);
        chk("end_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
